sd_wrr_mux: RTL and testbench
=============================

SD_WRR_MUX -- requirements
Module: sd_wrr_mux

Interface
REQ-001 Parameter width, 8, data bits per input and output.
REQ-002 Parameter inputs, 4, number of srdy/drdy requesters (2..16).
REQ-003 Parameter weight_sz, 4, bits per weight field.
REQ-004 Port clk  input  1  clock; all state on rising edge.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port c_srdy  input  inputs  per-requester source ready.
REQ-007 Port c_drdy  output  inputs  per-requester accept; at most one bit set per cycle.
REQ-008 Port c_data  input  inputs*width  requester i occupies bits [i*width +: width].
REQ-009 Port weights  input  inputs*weight_sz  burst credit per requester, static while traffic flows.
REQ-010 Port p_srdy  output  1  output holding register valid.
REQ-011 Port p_drdy  input  1  downstream accept.
REQ-012 Port p_data  output  width  output holding register contents.
REQ-013 Port p_grant  output  inputs  one-hot index of current grant owner, zero when no owner.
REQ-014 Port stat_cnt  output  inputs*16  per-requester transfer counters (see Configuration).

Function
REQ-015 The block SHALL have a one-entry output register; slot free = !p_srdy | p_drdy.
REQ-016 Transfer from requester i SHALL occur in a cycle where i is granted, c_srdy[i]=1 and slot free; c_drdy[i] = grant[i] & slot free.
REQ-017 Latency SHALL be one cycle: data accepted at edge N appears on p_data with p_srdy=1 after edge N.
REQ-018 If p_srdy & p_drdy with no new transfer, p_srdy SHALL clear; with a new transfer it SHALL stay 1 and load the new data (full throughput).
REQ-019 State: cur (last owner index), credit (weight_sz bits), owned flag.
REQ-020 If owned and c_srdy[cur]=1, grant SHALL remain with cur.
REQ-021 Otherwise grant SHALL go to the first requester with c_srdy set, searching cur+1, cur+2, ... wrapping modulo inputs, cur last.
REQ-022 On the first transfer of a new owner, credit SHALL load weight-1; weight 0 SHALL be treated as 1.
REQ-023 Each further transfer by the owner SHALL decrement credit; the transfer made at credit=0 SHALL clear owned.
REQ-024 If the owner drops c_srdy while owned, owned SHALL clear and remaining credit SHALL be discarded.
REQ-025 Grant changes with the slot full and p_drdy=0 SHALL not transfer and SHALL not alter credit.
REQ-026 No requester SHALL wait more than (inputs-1)*max(weight,1) transfers while continuously asserting c_srdy.

Reset
REQ-027 On reset: p_srdy=0, p_data=0, c_drdy=0, p_grant=0, owned=0, credit=0, cur=inputs-1 (requester 0 has first priority), stat_cnt=0.
REQ-028 Reset mid-burst SHALL drop the held output word without handshake.

Configuration
REQ-029 With SD_WRR_STATS_EN defined, stat_cnt[i] SHALL increment on each transfer from requester i, saturating at 16'hFFFF.
REQ-030 Without SD_WRR_STATS_EN, stat_cnt SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-031 Shared package sd_wrr_pkg SHALL hold the stat counter width (16) and the weight-0-as-1 rule constant.
REQ-032 Round-robin search SHALL be a combinational sub-module sd_rr_pick (request vector, last index -> one-hot winner).

Verification
REQ-033 All c_srdy=1, weights=1,2,1,3, p_drdy=1 -> grant order 0,1,1,2,3,3,3, repeating.
REQ-034 Only requester 2 requesting, weight 0 -> one transfer per cycle, p_grant=4'b0100 every cycle, zero idle cycles.
REQ-035 Owner 1 (weight 4) drops c_srdy after 2 transfers -> next cycle grant moves to 2; requester 1's next grant reloads credit to 3.
REQ-036 p_drdy held 0 for 5 cycles with p_srdy=1 -> all c_drdy=0, p_data and credit unchanged, no loss/duplication.
REQ-037 Four sd_seq_check-style incrementing streams tagged by input index, random p_drdy -> per-tag sequences intact at output, zero miscompares.
REQ-038 SD_WRR_STATS_EN defined, 70000 transfers from requester 0 -> stat_cnt[15:0]=16'hFFFF; undefined -> stat_cnt=0.

Source files
------------

// File: rtl/sd_wrr_pkg.sv
// Shared constants and types for the weighted round-robin srdy/drdy mux.
package sd_wrr_pkg;

  localparam int unsigned STAT_W     = 16;
  // A programmed weight of zero still earns one transfer per turn.
  localparam int unsigned WEIGHT_MIN = 1;

  typedef enum logic {
    OWN_FREE = 1'b0,
    OWN_BUSY = 1'b1
  } own_state_t;

endpackage

// File: rtl/sd_rr_pick.sv
// Combinational round-robin search: first requester after last_i, wrapping, last_i itself last.
module sd_rr_pick #(
  parameter int unsigned inputs = 4
) (
  input  logic [inputs-1:0]         req_i,
  input  logic [$clog2(inputs)-1:0] last_i,
  output logic [inputs-1:0]         win_o
);

  localparam int unsigned IW = $clog2(inputs);

  int unsigned   idx;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned k = 1; k <= inputs; k++) begin
      idx = 32'(last_i) + k;
      if (idx >= inputs) idx = idx - inputs;
      sel = IW'(idx);
      if (!found && req_i[sel]) begin
        win_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_wrr_mux.sv
// Weighted round-robin N:1 srdy/drdy mux with a one-entry output register.
// Define SD_WRR_STATS_EN to build the per-requester saturating transfer counters.
module sd_wrr_mux
  import sd_wrr_pkg::*;
#(
  parameter int unsigned width     = 8,
  parameter int unsigned inputs    = 4,
  parameter int unsigned weight_sz = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [inputs-1:0]           c_srdy,
  output logic [inputs-1:0]           c_drdy,
  input  logic [inputs*width-1:0]     c_data,
  input  logic [inputs*weight_sz-1:0] weights,
  output logic                        p_srdy,
  input  logic                        p_drdy,
  output logic [width-1:0]            p_data,
  output logic [inputs-1:0]           p_grant,
  output logic [inputs*STAT_W-1:0]    stat_cnt
);

  localparam int unsigned IW = $clog2(inputs);
  typedef logic [IW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(inputs - 1);

  own_state_t           own_q, own_d;
  idx_t                 cur_q, cur_d;
  logic [weight_sz-1:0] credit_q, credit_d;
  logic                 p_srdy_q, p_srdy_d;
  logic [width-1:0]     p_data_q, p_data_d;

  logic [width-1:0]     data_arr [inputs];
  logic [weight_sz-1:0] wt_arr   [inputs];
  logic [inputs-1:0]    pick, grant;
  idx_t                 gidx;
  logic                 hold, slot_free, xfer;
  logic [weight_sz-1:0] wload;

  sd_rr_pick #(.inputs(inputs)) u_pick (
    .req_i  (c_srdy),
    .last_i (cur_q),
    .win_o  (pick)
  );

  always_comb begin
    for (int unsigned i = 0; i < inputs; i++) begin
      data_arr[i] = c_data[i*width +: width];
      wt_arr[i]   = weights[i*weight_sz +: weight_sz];
    end
  end

  // The owner keeps the grant while it still has credit and keeps requesting.
  always_comb begin
    hold  = (own_q == OWN_BUSY) && c_srdy[cur_q];
    grant = '0;
    if (!reset) begin
      if (hold) grant[cur_q] = 1'b1;
      else      grant        = pick;
    end
    gidx = '0;
    for (int unsigned i = 0; i < inputs; i++) begin
      if (grant[i]) gidx = idx_t'(i);
    end
    slot_free = !p_srdy_q || p_drdy;
    c_drdy    = grant & {inputs{slot_free}};
    xfer      = |(c_drdy & c_srdy);
    wload     = (wt_arr[gidx] == '0) ? weight_sz'(WEIGHT_MIN) : wt_arr[gidx];
  end

  // Credit counts the extra transfers left; the one that exhausts it releases ownership.
  always_comb begin
    own_d    = own_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    if ((own_q == OWN_BUSY) && !c_srdy[cur_q]) begin
      own_d    = OWN_FREE;
      credit_d = '0;
    end
    if (xfer) begin
      if (hold) begin
        credit_d = (credit_q == '0) ? '0 : credit_q - weight_sz'(1);
        own_d    = ((credit_q == '0) || (credit_q == weight_sz'(1))) ? OWN_FREE : OWN_BUSY;
      end else begin
        cur_d    = gidx;
        credit_d = wload - weight_sz'(1);
        own_d    = (wload == weight_sz'(1)) ? OWN_FREE : OWN_BUSY;
      end
    end
  end

  always_comb begin
    p_srdy_d = p_srdy_q;
    p_data_d = p_data_q;
    if (xfer) begin
      p_srdy_d = 1'b1;
      p_data_d = data_arr[gidx];
    end else if (p_drdy) begin
      p_srdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q    <= OWN_FREE;
      cur_q    <= LAST_IDX;
      credit_q <= '0;
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
    end else begin
      own_q    <= own_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
      p_srdy_q <= p_srdy_d;
      p_data_q <= p_data_d;
    end
  end

  assign p_srdy  = p_srdy_q;
  assign p_data  = p_data_q;
  assign p_grant = grant;

`ifdef SD_WRR_STATS_EN
  logic [STAT_W-1:0] stat_q [inputs];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < inputs; i++) begin
      if (reset) begin
        stat_q[i] <= '0;
      end else if (c_drdy[i] && c_srdy[i] && (stat_q[i] != '1)) begin
        stat_q[i] <= stat_q[i] + STAT_W'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < inputs; i++) begin
      stat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
    end
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_sd_wrr_mux.sv
// Scoreboard bench for sd_wrr_mux: directed streams with hand-computed grant orders.
module tb_sd_wrr_mux;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int WS = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   c_srdy, c_drdy, p_grant;
  logic [N*W-1:0] c_data;
  logic [N*WS-1:0] weights;
  logic           p_srdy, p_drdy;
  logic [W-1:0]   p_data;
  logic [N*16-1:0] stat_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [5:0]   drv_seq[N];
  logic [5:0]   exp_seq[N];
  int           tot[N];
  int           pat_a[7] = '{0, 1, 1, 2, 3, 3, 3};
  int           pat_c1[3] = '{1, 1, 2};
  int           pat_c2[7] = '{1, 1, 1, 1, 2, 1, 2};

  sd_wrr_mux #(.width(W), .inputs(N), .weight_sz(WS)) dut (
    .clk      (clk),
    .reset    (reset),
    .c_srdy   (c_srdy),
    .c_drdy   (c_drdy),
    .c_data   (c_data),
    .weights  (weights),
    .p_srdy   (p_srdy),
    .p_drdy   (p_drdy),
    .p_data   (p_data),
    .p_grant  (p_grant),
    .stat_cnt (stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_tag(input int t);
    exp_q.push_back({2'(t), exp_seq[t]});
    exp_seq[t] = exp_seq[t] + 6'd1;
  endtask

  task automatic clear_tot();
    for (int i = 0; i < N; i++) tot[i] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    clear_tot();
  endtask

  task automatic check_stats();
    for (int i = 0; i < N; i++) begin
`ifdef SD_WRR_STATS_EN
      check("stat_cnt", 32'(stat_cnt[i*16 +: 16]), 32'(tot[i]));
`else
      check("stat_cnt", 32'(stat_cnt[i*16 +: 16]), 32'd0);
`endif
    end
  endtask

  // mode 0: p_drdy=1; mode 1: random p_drdy; mode 2: p_drdy low for cycles 3..7
  task automatic run_stream(input int r0, input int r1, input int r2, input int r3,
                            input int mode, input logic [N-1:0] gexp);
    int rem[N];
    int cyc;
    int limit;
    logic [N-1:0] acc;
    rem = '{r0, r1, r2, r3};
    limit = 2 * (r0 + r1 + r2 + r3) + 100;
    for (int i = 0; i < N; i++) tot[i] += rem[i];
    cyc = 0;
    while (((rem[0] + rem[1] + rem[2] + rem[3]) > 0 || exp_q.size() > 0) && cyc < limit) begin
      for (int i = 0; i < N; i++) begin
        c_srdy[i] = (rem[i] > 0);
        c_data[i*W +: W] = {2'(i), drv_seq[i]};
      end
      case (mode)
        1:       p_drdy = 1'($urandom_range(0, 1));
        2:       p_drdy = !(cyc >= 3 && cyc < 8);
        default: p_drdy = 1'b1;
      endcase
      @(negedge clk);
      if (p_srdy && !p_drdy) check("stall_c_drdy", 32'(c_drdy), 32'd0);
      if (mode == 2 && !p_drdy) check("stall_p_srdy", 32'(p_srdy), 32'd1);
      if (gexp != '0 && rem[2] > 0) begin
        check("solo_p_grant", 32'(p_grant), 32'(gexp));
        check("solo_c_drdy", 32'(c_drdy), 32'(gexp));
      end
      acc = c_srdy & c_drdy;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          drv_seq[i] = drv_seq[i] + 6'd1;
          rem[i]--;
        end
      end
      cyc++;
    end
    if (cyc >= limit) begin
      n_checks++;
      $display("FAIL stream_timeout: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    c_srdy = '0;
    p_drdy = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!reset && p_srdy && p_drdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 32'(p_data), 32'hFFFF_FFFF);
      end else begin
        check("p_data", 32'(p_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      drv_seq[i] = '0;
      exp_seq[i] = '0;
    end
    clear_tot();
    reset   = 1'b1;
    c_srdy  = '1;
    c_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
    weights = {4'd3, 4'd1, 4'd2, 4'd1};
    p_drdy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p_srdy", 32'(p_srdy), 32'd0);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_c_drdy", 32'(c_drdy), 32'd0);
    check("rst_p_grant", 32'(p_grant), 32'd0);
    check_stats();

    // first grant after reset goes to requester 0; then reset drops the held word
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("first_p_grant", 32'(p_grant), 32'h1);
    check("first_c_drdy", 32'(c_drdy), 32'h1);
    @(posedge clk); #1 c_srdy = '0;
    @(negedge clk);
    check("held_p_srdy", 32'(p_srdy), 32'd1);
    check("held_p_data", 32'(p_data), 32'hA5);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("drop_p_srdy", 32'(p_srdy), 32'd0);
    check("drop_p_data", 32'(p_data), 32'd0);
    check("drop_p_grant", 32'(p_grant), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    clear_tot();

    // weights 1,2,1,3, everyone requesting, full throughput
    for (int r = 0; r < 2; r++) for (int k = 0; k < 7; k++) push_tag(pat_a[k]);
    run_stream(2, 4, 2, 6, 0, '0);

    // same traffic with a 5-cycle downstream stall
    for (int r = 0; r < 2; r++) for (int k = 0; k < 7; k++) push_tag(pat_a[k]);
    run_stream(2, 4, 2, 6, 2, '0);

    // random downstream back-pressure, three full rounds
    for (int r = 0; r < 3; r++) for (int k = 0; k < 7; k++) push_tag(pat_a[k]);
    run_stream(3, 6, 3, 9, 1, '0);
    check_stats();

    // lone requester 2 with weight 0
    weights = {4'd3, 4'd0, 4'd2, 4'd1};
    for (int k = 0; k < 8; k++) push_tag(2);
    run_stream(0, 0, 8, 0, 0, 4'b0100);

    // owner 1 (weight 4) drops after 2, then regains a full burst of 4
    do_reset();
    weights = {4'd3, 4'd1, 4'd4, 4'd1};
    for (int k = 0; k < 3; k++) push_tag(pat_c1[k]);
    run_stream(0, 2, 1, 0, 0, '0);
    for (int k = 0; k < 7; k++) push_tag(pat_c2[k]);
    run_stream(0, 5, 2, 0, 0, '0);
    check_stats();

`ifdef SD_WRR_STATS_EN
    do_reset();
    for (int k = 0; k < 70000; k++) push_tag(0);
    run_stream(70000, 0, 0, 0, 0, '0);
    check("sat_stat0", 32'(stat_cnt[15:0]), 32'hFFFF);
    check("sat_stat1", 32'(stat_cnt[31:16]), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
